// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//
// Time-setting controller for the digital clock. Turns keypad events into an
// hour -> minute -> second edit session on shadow registers, then commits the
// edited time to the time counter with a one-cycle load strobe. Also drives the
// display mux (edit-mode select, selected field, blink gate).
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   key_valid, key_code  key strobe (edge-detected here) and 4-bit key id
//   tick_1hz             one-cycle pulse per second (timeout and blink base)
//   cur_hour/min/sec     running time, snapshotted when an edit session opens
//   editing              high while a SET state is active
//   sel_field            0 none, 1 hour, 2 minute, 3 second
//   blink                1 = selected field visible, 0 = blanked
//   edit_hour/min/sec    shadow time being edited
//   time_load            one-cycle commit strobe for the time counter
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT_S = 10  // legal 1..63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       editing,
    output logic [1:0] sel_field,
    output logic       blink,
    output logic [4:0] edit_hour,
    output logic [5:0] edit_min,
    output logic [5:0] edit_sec,
    output logic       time_load
);

    typedef enum logic [2:0] {
        StIdle,
        StSetH,
        StSetM,
        StSetS,
        StCommit
    } state_e;

    localparam logic [3:0] KeyMode  = 4'h1;
    localparam logic [3:0] KeyUp    = 4'h2;
    localparam logic [3:0] KeyDown  = 4'h3;
    localparam logic [3:0] KeyEnter = 4'h4;
    localparam logic [3:0] KeyEsc   = 4'hF;

    localparam logic [5:0] TimeoutLimit = 6'(TIMEOUT_S);

    state_e     state_q, state_d;
    logic       key_valid_q, key_valid_d;
    logic [5:0] timeout_q, timeout_d;
    logic       blink_q, blink_d;
    logic [4:0] edit_hour_q, edit_hour_d;
    logic [5:0] edit_min_q, edit_min_d;
    logic [5:0] edit_sec_q, edit_sec_d;
    logic       editing_q, editing_d;
    logic [1:0] sel_field_q, sel_field_d;
    logic       time_load_q, time_load_d;

    logic       key_event;
    logic       key_known;
    logic [5:0] timeout_inc;

    always_comb begin
        key_event   = key_valid & ~key_valid_q;
        timeout_inc = timeout_q + 6'd1;

        // Only recognised codes count as activity; others must not restart the timeout.
        case (key_code)
            KeyMode, KeyUp, KeyDown, KeyEnter, KeyEsc: key_known = key_event;
            default:                                   key_known = 1'b0;
        endcase

        state_d     = state_q;
        key_valid_d = key_valid;
        timeout_d   = timeout_q;
        blink_d     = blink_q;
        edit_hour_d = edit_hour_q;
        edit_min_d  = edit_min_q;
        edit_sec_d  = edit_sec_q;

        case (state_q)
            StIdle: begin
                if (key_event && key_code == KeyMode) begin
                    edit_hour_d = cur_hour;
                    edit_min_d  = cur_min;
                    edit_sec_d  = cur_sec;
                    state_d     = StSetH;
                    timeout_d   = 6'd0;
                    blink_d     = 1'b1;
                end
            end
            StSetH, StSetM, StSetS: begin
                if (key_known) begin
                    // Key beats a coincident tick, including the terminal one.
                    timeout_d = 6'd0;
                    blink_d   = 1'b1;
                    case (key_code)
                        KeyMode: begin
                            case (state_q)
                                StSetH:  state_d = StSetM;
                                StSetM:  state_d = StSetS;
                                default: state_d = StSetH;
                            endcase
                        end
                        KeyUp: begin
                            case (state_q)
                                StSetH: edit_hour_d = (edit_hour_q >= 5'd23) ? 5'd0
                                                                             : edit_hour_q + 5'd1;
                                StSetM: edit_min_d  = (edit_min_q >= 6'd59) ? 6'd0
                                                                            : edit_min_q + 6'd1;
                                default: edit_sec_d = (edit_sec_q >= 6'd59) ? 6'd0
                                                                            : edit_sec_q + 6'd1;
                            endcase
                        end
                        KeyDown: begin
                            case (state_q)
                                StSetH: edit_hour_d = (edit_hour_q == 5'd0 || edit_hour_q > 5'd23)
                                                      ? 5'd23 : edit_hour_q - 5'd1;
                                StSetM: edit_min_d  = (edit_min_q == 6'd0 || edit_min_q > 6'd59)
                                                      ? 6'd59 : edit_min_q - 6'd1;
                                default: edit_sec_d = (edit_sec_q == 6'd0 || edit_sec_q > 6'd59)
                                                      ? 6'd59 : edit_sec_q - 6'd1;
                            endcase
                        end
                        KeyEnter: state_d = StCommit;
                        default:  state_d = StIdle;  // ESC
                    endcase
                end else if (tick_1hz) begin
                    blink_d = ~blink_q;
                    if (timeout_inc == TimeoutLimit) begin
                        state_d   = StIdle;
                        timeout_d = 6'd0;
                    end else begin
                        timeout_d = timeout_inc;
                    end
                end
            end
            StCommit: begin
                // edit_* held; keys arriving here are dropped.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        editing_d   = 1'b0;
        sel_field_d = 2'd0;
        time_load_d = 1'b0;
        case (state_d)
            StSetH: begin
                editing_d   = 1'b1;
                sel_field_d = 2'd1;
            end
            StSetM: begin
                editing_d   = 1'b1;
                sel_field_d = 2'd2;
            end
            StSetS: begin
                editing_d   = 1'b1;
                sel_field_d = 2'd3;
            end
            StCommit: begin
                time_load_d = 1'b1;
                blink_d     = 1'b1;
            end
            default: begin
                blink_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            key_valid_q <= 1'b0;
            timeout_q   <= 6'd0;
            blink_q     <= 1'b1;
            edit_hour_q <= 5'd0;
            edit_min_q  <= 6'd0;
            edit_sec_q  <= 6'd0;
            editing_q   <= 1'b0;
            sel_field_q <= 2'd0;
            time_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            timeout_q   <= timeout_d;
            blink_q     <= blink_d;
            edit_hour_q <= edit_hour_d;
            edit_min_q  <= edit_min_d;
            edit_sec_q  <= edit_sec_d;
            editing_q   <= editing_d;
            sel_field_q <= sel_field_d;
            time_load_q <= time_load_d;
        end
    end

    assign editing   = editing_q;
    assign sel_field = sel_field_q;
    assign blink     = blink_q;
    assign edit_hour = edit_hour_q;
    assign edit_min  = edit_min_q;
    assign edit_sec  = edit_sec_q;
    assign time_load = time_load_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios with literal expectations, then
// randomized key/tick/reset traffic checked every cycle against a behavioural model.
module tb_clock_set_ctrl;

    localparam int unsigned TO = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       tick_1hz = 1'b0;
    logic [4:0] cur_hour = 5'd0;
    logic [5:0] cur_min = 6'd0;
    logic [5:0] cur_sec = 6'd0;
    logic       editing;
    logic [1:0] sel_field;
    logic       blink;
    logic [4:0] edit_hour;
    logic [5:0] edit_min;
    logic [5:0] edit_sec;
    logic       time_load;

    clock_set_ctrl #(.TIMEOUT_S(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .tick_1hz  (tick_1hz),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .editing   (editing),
        .sel_field (sel_field),
        .blink     (blink),
        .edit_hour (edit_hour),
        .edit_min  (edit_min),
        .edit_sec  (edit_sec),
        .time_load (time_load)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int load_count = 0;
    bit check_en = 1'b0;

    // Behavioural model. mode: 0 idle, 1 hour, 2 minute, 3 second, 4 commit.
    int m_mode = 0;
    int m_h = 0, m_m = 0, m_s = 0, m_to = 0;
    bit m_blink = 1'b1;
    bit m_prev = 1'b0;
    bit ev, rec;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_to = 0; m_blink = 1'b1; m_prev = 1'b0;
        end else begin
            ev = key_valid && !m_prev;
            m_prev = key_valid;
            rec = ev && (key_code inside {4'h1, 4'h2, 4'h3, 4'h4, 4'hF});
            if (m_mode == 0) begin
                if (ev && key_code == 4'h1) begin
                    m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
                    m_mode = 1; m_to = 0;
                end
            end else if (m_mode == 4) begin
                m_mode = 0;
            end else if (rec) begin
                m_to = 0;
                m_blink = 1'b1;
                case (key_code)
                    4'h1: m_mode = (m_mode % 3) + 1;
                    4'h2: begin
                        if (m_mode == 1) m_h = (m_h + 1) % 24;
                        else if (m_mode == 2) m_m = (m_m + 1) % 60;
                        else m_s = (m_s + 1) % 60;
                    end
                    4'h3: begin
                        if (m_mode == 1) m_h = (m_h + 23) % 24;
                        else if (m_mode == 2) m_m = (m_m + 59) % 60;
                        else m_s = (m_s + 59) % 60;
                    end
                    4'h4: m_mode = 4;
                    default: m_mode = 0;
                endcase
            end else if (tick_1hz) begin
                m_to++;
                m_blink = !m_blink;
                if (m_to == TO) begin
                    m_mode = 0;
                    m_to = 0;
                end
            end
            if (m_mode == 0 || m_mode == 4) m_blink = 1'b1;
        end
    end

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge clk) begin
        int exp_ed, exp_sel, exp_ld;
        if (check_en) begin
            exp_ed  = (m_mode >= 1 && m_mode <= 3) ? 1 : 0;
            exp_sel = (m_mode >= 1 && m_mode <= 3) ? m_mode : 0;
            exp_ld  = (m_mode == 4) ? 1 : 0;
            n_cmp++;
            if (editing !== exp_ed[0] || sel_field !== exp_sel[1:0] || blink !== m_blink ||
                edit_hour !== m_h[4:0] || edit_min !== m_m[5:0] || edit_sec !== m_s[5:0] ||
                time_load !== exp_ld[0]) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t act ed=%b sel=%0d bl=%b %0d:%0d:%0d ld=%b exp ed=%0d sel=%0d bl=%b %0d:%0d:%0d ld=%0d",
                         $time, editing, sel_field, blink, edit_hour, edit_min, edit_sec,
                         time_load, exp_ed, exp_sel, m_blink, m_h, m_m, m_s, exp_ld);
            end
            if (time_load === 1'b1) load_count++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        step(1);
        key_valid = 1'b0;
        step(1);
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        int loads0;
        logic [3:0] codes [10];
        codes = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'hF, 4'h0, 4'h7};

        step(2);
        check_en = 1'b1;
        reset = 1'b0;
        chk("reset_editing", editing, 0);
        chk("reset_blink", blink, 1);
        chk("reset_edit_hour", edit_hour, 0);
        step(1);

        // Hold check: MODE held for five cycles gives exactly one transition.
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        key_valid = 1'b1; key_code = 4'h1;
        step(5);
        key_valid = 1'b0;
        step(1);
        chk("hold_editing", editing, 1);
        chk("hold_sel", sel_field, 1);
        chk("hold_hour", edit_hour, 12);
        chk("hold_min", edit_min, 34);
        chk("hold_sec", edit_sec, 56);

        // Wrap and commit.
        do_reset();
        cur_hour = 5'd23; cur_min = 6'd0; cur_sec = 6'd56;
        key(4'h1);
        cur_hour = 5'd4;  // counter moves after the snapshot; must not matter
        chk("snap_hour", edit_hour, 23);
        key(4'h2);
        chk("wrap_hour_up", edit_hour, 0);
        key(4'h1);
        chk("sel_min", sel_field, 2);
        key(4'h3);
        chk("wrap_min_down", edit_min, 59);
        loads0 = load_count;
        key_valid = 1'b1; key_code = 4'h4;
        step(1);
        chk("commit_load", time_load, 1);
        chk("commit_editing", editing, 0);
        chk("commit_hour", edit_hour, 0);
        chk("commit_min", edit_min, 59);
        chk("commit_sec", edit_sec, 56);
        key_valid = 1'b0;
        step(2);
        chk("commit_one_pulse", load_count - loads0, 1);

        // ESC keeps edits, no load.
        cur_hour = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
        key(4'h1);
        key(4'h2);
        loads0 = load_count;
        key(4'hF);
        chk("esc_editing", editing, 0);
        chk("esc_hour_kept", edit_hour, 6);
        chk("esc_no_load", load_count - loads0, 0);

        // Timeout with TIMEOUT_S = 3 and blink toggling.
        loads0 = load_count;
        key(4'h1);
        tick();
        chk("to_blink1", blink, 0);
        tick();
        chk("to_blink2", blink, 1);
        key(4'h2);
        tick();
        chk("to_blink3", blink, 0);
        tick();
        chk("to_blink4", blink, 1);
        chk("to_still_editing", editing, 1);
        tick();
        chk("to_expired", editing, 0);
        chk("to_no_load", load_count - loads0, 0);

        // Ignored codes in SET_M keep the timeout running.
        key(4'h1);
        key(4'h1);
        tick();
        key(4'h0);
        key(4'h5);
        key(4'hE);
        chk("ign_sel", sel_field, 2);
        chk("ign_blink", blink, 0);
        tick();
        chk("ign_editing", editing, 1);
        tick();
        chk("ign_timeout", editing, 0);

        // MODE x3 rolls back to hour.
        key(4'h1);
        key(4'h1);
        key(4'h1);
        key(4'h1);
        chk("mode_wrap", sel_field, 1);

        // Reset mid-session from SET_S with a pending edit.
        key(4'h1);
        key(4'h1);
        key(4'h2);
        loads0 = load_count;
        reset = 1'b1;
        step(1);
        chk("rst_editing", editing, 0);
        chk("rst_sel", sel_field, 0);
        chk("rst_blink", blink, 1);
        chk("rst_time", {27'd0, edit_hour, edit_min, edit_sec}, 0);
        chk("rst_load", time_load, 0);
        reset = 1'b0;
        step(1);
        chk("rst_no_load", load_count - loads0, 0);

        // Randomized traffic, model checked every cycle.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_code  = codes[$urandom_range(0, 9)];
            tick_1hz  = ($urandom_range(0, 3) == 0);
            cur_hour  = 5'($urandom_range(0, 23));
            cur_min   = 6'($urandom_range(0, 59));
            cur_sec   = 6'($urandom_range(0, 59));
            step(1);
        end
        reset = 1'b0; key_valid = 1'b0; tick_1hz = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
